// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential 16-bit binary to 5-digit BCD converter using the shift-and-add-3
//   ("double dabble") algorithm, one bit per clock.
//
//   Ports:
//     clk            system clock, all state changes on the rising edge
//     rst            synchronous, active-high reset
//     start          conversion request, sampled only while idle
//     bin[15:0]      unsigned binary value to convert
//     busy           high during the 16 shift cycles
//     done           one-cycle pulse; bcd4..bcd0 carry the new result in that cycle
//     bcd4..bcd0     registered BCD digits (bcd4 = ten-thousands, bcd0 = units)
//
//   Timing: start sampled at edge T -> busy for the 16 cycles after T..T+15,
//   one DONE state cycle, then done=1 with fresh digits after edge T+17.
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd4,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q,   state_d;
  logic [15:0] shreg_q,   shreg_d;
  logic [19:0] scratch_q, scratch_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic [19:0] bcd_q,     bcd_d;
  logic        done_q,    done_d;

  // Scratch digits after the add-3 correction; each nibble is corrected on its
  // own with no carry into its neighbour.
  logic [19:0] corrected;
  // Combined scratch/shift word after the one-bit left shift.
  logic [35:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_digit_fix
      assign corrected[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                    ? scratch_q[gi*4 +: 4] + 4'd3
                                    : scratch_q[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {corrected[18:0], shreg_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = 20'd0;
          cnt_d     = 4'd0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        scratch_d = shifted[35:16];
        shreg_d   = shifted[15:0];
        cnt_d     = cnt_q + 4'd1;
        // cnt_q counts shifts already done; 15 means this is the 16th.
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Only here does the scratch register reach the outputs, so partial
        // results are never visible downstream.
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= 16'd0;
      scratch_q <= 20'd0;
      cnt_q     <= 4'd0;
      bcd_q     <= 20'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd4 = bcd_q[19:16];
  assign bcd3 = bcd_q[15:12];
  assign bcd2 = bcd_q[11:8];
  assign bcd1 = bcd_q[7:4];
  assign bcd0 = bcd_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed vector table, hand-written multi-cycle
// sequences (overlapping start, reset abort, back-to-back, reset vs start) and a
// random sweep. Inputs change and outputs are sampled on the falling edge.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  bcd4, bcd3, bcd2, bcd1, bcd0;
  logic [19:0] dig;

  int n_tests;
  int n_fail;
  int mon_fail;

  bin_to_bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd4  (bcd4),
    .bcd3  (bcd3),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0)
  );

  assign dig = {bcd4, bcd3, bcd2, bcd1, bcd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic [19:0] e;
  } vec_t;

  vec_t tbl [10];

  // Reference: decimal digits of v by integer arithmetic.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r[19:16] = 4'(v / 10000);
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle invariants: digits legal, busy/done exclusive.
  always @(negedge clk) begin
    if (!rst) begin
      if (bcd4 > 4'd6 || bcd3 > 4'd9 || bcd2 > 4'd9 || bcd1 > 4'd9 || bcd0 > 4'd9) begin
        mon_fail++;
        $display("FAIL digit_range: got %h expected digits<=9, bcd4<=6", dig);
      end
      if (busy && done) begin
        mon_fail++;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
      end
    end
  end

  // One conversion with a single-cycle start; checks latency, busy length,
  // single done pulse, result and hold afterwards.
  task automatic conv(input logic [15:0] b, input logic [19:0] e, input string name);
    int busy_cnt, done_idx, done_cnt;
    logic [19:0] got;
    busy_cnt = 0; done_idx = -1; done_cnt = 0; got = '0;
    @(negedge clk);
    bin = b; start = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i;
          got = dig;
        end
      end
    end
    check({name, "_busy_len"}, busy_cnt, 16);
    check({name, "_done_idx"}, done_idx, 18);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_digits"}, {12'd0, got}, {12'd0, e});
    check({name, "_hold"}, {12'd0, dig}, {12'd0, e});
    $display("[TB] conv %s bin=%0d digits=%h expected=%h", name, b, got, e);
  endtask

  initial begin
    int done_cnt, done_idx, d1, d2;
    logic [19:0] got, got2;
    logic [15:0] rv;

    n_tests = 0; n_fail = 0; mon_fail = 0;
    rst = 1'b1; start = 1'b0; bin = 16'd0;

    tbl[0] = '{16'd0,     20'h00000};
    tbl[1] = '{16'd65535, 20'h65535};
    tbl[2] = '{16'd1023,  20'h01023};
    tbl[3] = '{16'd9999,  20'h09999};
    tbl[4] = '{16'd9,     20'h00009};
    tbl[5] = '{16'd10,    20'h00010};
    tbl[6] = '{16'd99,    20'h00099};
    tbl[7] = '{16'd100,   20'h00100};
    tbl[8] = '{16'd59999, 20'h59999};
    tbl[9] = '{16'd42,    20'h00042};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_digits", {12'd0, dig}, 0);
    $display("[TB] reset busy=%b done=%b digits=%h", busy, done, dig);
    rst = 1'b0;

    // Directed table.
    for (int k = 0; k < 10; k++) begin
      conv(tbl[k].b, tbl[k].e, $sformatf("vec%0d", k));
    end

    // Result 42 held across idle cycles, then reset aborts a 500 conversion.
    repeat (5) @(negedge clk);
    check("hold_42", {12'd0, dig}, 32'h00042);
    @(negedge clk);
    bin = 16'd500; start = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 8) rst = 1'b1;
      if (i == 9) begin
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_digits", {12'd0, dig}, 0);
        rst = 1'b0;
      end
      if (i > 9 && (done || busy)) done_cnt++;
    end
    check("abort_no_activity", done_cnt, 0);
    $display("[TB] abort 500 digits=%h activity=%0d", dig, done_cnt);

    // Second start during SHIFT ignored; bin change after capture ignored.
    @(negedge clk);
    bin = 16'd12345; start = 1'b1;
    done_cnt = 0; done_idx = -1; got = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin bin = 16'd1; start = 1'b1; end
      if (i == 6) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin done_idx = i; got = dig; end
      end
    end
    check("overlap_done_cnt", done_cnt, 1);
    check("overlap_done_idx", done_idx, 18);
    check("overlap_digits", {12'd0, got}, 32'h12345);
    $display("[TB] overlap digits=%h dones=%0d", got, done_cnt);

    // start held high: results 18 cycles apart.
    @(negedge clk);
    bin = 16'd7; start = 1'b1;
    done_cnt = 0; d1 = -1; d2 = -1; got = '0; got2 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bin = 16'd8;
      if (i == 19) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (d1 < 0) begin d1 = i; got = dig; end
        else if (d2 < 0) begin d2 = i; got2 = dig; end
      end
    end
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_first_idx", d1, 18);
    check("b2b_spacing", d2 - d1, 18);
    check("b2b_first_digits", {12'd0, got}, 32'h00007);
    check("b2b_second_digits", {12'd0, got2}, 32'h00008);
    $display("[TB] back-to-back %h at %0d, %h at %0d", got, d1, got2, d2);

    // Reset wins over start; start honoured on the first cycle after.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; bin = 16'd77;
    @(negedge clk);
    check("rst_prio_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_busy", {31'd0, busy}, 1);
    start = 1'b0;
    done_cnt = 0; got = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin done_cnt++; got = dig; end
    end
    check("rst_release_done_cnt", done_cnt, 1);
    check("rst_release_digits", {12'd0, got}, 32'h00077);
    $display("[TB] rst/start priority digits=%h", got);

    // Random sweep.
    for (int k = 0; k < 1000; k++) begin
      rv = 16'($urandom_range(0, 65535));
      conv(rv, to_bcd(int'(rv)), $sformatf("rnd%0d", k));
    end

    check("monitor_violations", mon_fail, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound in case the flow stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before bound");
    $fatal(1, "timeout");
  end

endmodule
